// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: instruction handshake and register-file port bundle for the sequencer
interface regfile_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs;
  logic [ADDR_W-1:0] in_rt;
  logic [DATA_W-1:0] in_imm;
  logic [ADDR_W-1:0] rf_ra;
  logic [ADDR_W-1:0] rf_rb;
  logic [ADDR_W-1:0] rf_rw;
  logic              rf_wren;
  logic [DATA_W-1:0] rf_busw;
  logic [DATA_W-1:0] rf_busa;
  logic [DATA_W-1:0] rf_busb;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              flag_z;
  logic              flag_c;
  modport master (
    input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, rf_busa, rf_busb,
    output in_ready, rf_ra, rf_rb, rf_rw, rf_wren, rf_busw, done, result, flag_z, flag_c
  );
  modport slave (
    output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, rf_busa, rf_busb,
    input  in_ready, rf_ra, rf_rb, rf_rw, rf_wren, rf_busw, done, result, flag_z, flag_c
  );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: one-at-a-time three-address instruction sequencer for a registered-read register file
module regfile_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst,
  regfile_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC} state_t;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_LI = 3'd7;
  state_t state, state_nxt;
  logic fire, exec, carry, flag_z, flag_c, done;
  logic [2:0] op;
  logic [ADDR_W-1:0] rd, rs, rt, rw;
  logic [DATA_W-1:0] imm, alu, result;
  logic [DATA_W:0] sum, dif;
  assign fire = bus.in_valid && state == IDLE;
  assign exec = state == EXEC;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (fire ? (bus.in_op == OP_LI ? EXEC : READ) : IDLE) :
                state == READ ? EXEC : IDLE;
  // write port is live only in EXEC; otherwise it shows the last write
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.rf_wren  = exec;
    bus.rf_ra    = rs;
    bus.rf_rb    = rt;
    bus.rf_rw    = exec ? rd : rw;
    bus.rf_busw  = exec ? alu : result;
    bus.done     = done;
    bus.result   = result;
    bus.flag_z   = flag_z;
    bus.flag_c   = flag_c;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      op  <= '0;
      rd  <= '0;
      rs  <= '0;
      rt  <= '0;
      imm <= '0;
    end else if (fire) begin
      op  <= bus.in_op;
      rd  <= bus.in_rd;
      rs  <= bus.in_rs;
      rt  <= bus.in_rt;
      imm <= bus.in_imm;
    end
  assign sum = {1'b0, bus.rf_busa} + {1'b0, bus.rf_busb};
  assign dif = {1'b0, bus.rf_busa} - {1'b0, bus.rf_busb};
  always_comb begin
    alu = imm;
    case (op)
      OP_ADD: alu = sum[DATA_W-1:0];
      OP_SUB: alu = dif[DATA_W-1:0];
      OP_AND: alu = bus.rf_busa & bus.rf_busb;
      OP_OR:  alu = bus.rf_busa | bus.rf_busb;
      OP_XOR: alu = bus.rf_busa ^ bus.rf_busb;
      OP_SLL: alu = bus.rf_busa << bus.rf_busb[3:0];
      OP_SRL: alu = bus.rf_busa >> bus.rf_busb[3:0];
      default: alu = imm;
    endcase
  end
  // the extra sum bit is carry for ADD and borrow for SUB
  assign carry = op == OP_ADD ? sum[DATA_W] : op == OP_SUB ? dif[DATA_W] : 1'b0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      done   <= 1'b0;
      rw     <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      done <= exec;
      if (exec) begin
        rw     <= rd;
        result <= alu;
        flag_z <= alu == '0;
        flag_c <= carry;
      end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed instructions against a behavioural register-file/sequencer model
module tb_regfile_sequencer;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, LI = 3'd7;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  regfile_sequencer_if #(.DATA_W(16), .ADDR_W(5)) bus();
  regfile_sequencer #(.DATA_W(16), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [15:0] rf_mem [32] = '{default: 16'h0};
  always @(posedge clk) begin
    bus.rf_busa <= rf_mem[bus.rf_ra];
    bus.rf_busb <= rf_mem[bus.rf_rb];
    if (bus.rf_wren) rf_mem[bus.rf_rw] <= bus.rf_busw;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] imm, output logic [15:0] v, output bit c);
    int unsigned ua, ub, s;
    ua = a;
    ub = b;
    c = 1'b0;
    case (op)
      ADD: begin s = ua + ub; v = s[15:0]; c = s > 32'd65535; end
      SUB: begin s = ua - ub; v = s[15:0]; c = ua < ub; end
      AND_: v = a & b;
      OR_: v = a | b;
      XOR_: v = a ^ b;
      SLL: v = a << b[3:0];
      SRL: v = a >> b[3:0];
      default: v = imm;
    endcase
  endfunction
  logic [15:0] m_rf [32] = '{default: 16'h0};
  int cyc = 0, m_wcyc = -10, m_dcyc = -10;
  bit m_busy, m_z, m_c, m_vc, acc;
  logic [4:0] m_rd, m_rs, m_rt, m_lrw;
  logic [15:0] m_val, m_res, m_lbusw;
  initial forever begin
    @(posedge clk);
    acc = rst && bus.in_valid && !m_busy;
    cyc++;
    if (!rst) begin
      m_busy = 0; m_wcyc = -10; m_dcyc = -10;
      m_rd = 0; m_rs = 0; m_rt = 0; m_lrw = 0; m_lbusw = 0;
      m_res = 0; m_z = 0; m_c = 0;
    end else begin
      if (cyc == m_dcyc) begin
        m_rf[m_rd] = m_val;
        m_res = m_val; m_z = m_val == 16'h0; m_c = m_vc;
        m_lrw = m_rd; m_lbusw = m_val; m_busy = 0;
      end
      if (acc) begin
        m_rd = bus.in_rd; m_rs = bus.in_rs; m_rt = bus.in_rt;
        model_alu(bus.in_op, m_rf[bus.in_rs], m_rf[bus.in_rt], bus.in_imm, m_val, m_vc);
        m_wcyc = cyc + (bus.in_op == LI ? 0 : 1);
        m_dcyc = m_wcyc + 1;
        m_busy = 1;
      end
    end
    #1;
    if (rst) begin
      chk("in_ready", bus.in_ready, !m_busy);
      chk("rf_wren", bus.rf_wren, cyc == m_wcyc);
      chk("rf_ra", bus.rf_ra, m_rs);
      chk("rf_rb", bus.rf_rb, m_rt);
      chk("rf_rw", bus.rf_rw, cyc == m_wcyc ? m_rd : m_lrw);
      chk("rf_busw", bus.rf_busw, cyc == m_wcyc ? m_val : m_lbusw);
      chk("done", bus.done, cyc == m_dcyc);
      chk("result", bus.result, m_res);
      chk("flag_z", bus.flag_z, m_z);
      chk("flag_c", bus.flag_c, m_c);
    end
  end
  task automatic offer(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [15:0] imm);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt; bus.in_imm = imm;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      $display("FAIL accept_timeout actual=%0h required=1", bus.in_ready);
      $fatal(1, "accept timeout");
    end
    @(posedge clk);
  endtask
  task automatic wait_done(output int lat);
    int n;
    lat = 1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      n++;
    end while (!bus.done && n < 10);
    chk("done_seen", bus.done, 1);
  endtask
  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [15:0] imm, input bit keep, output int lat);
    offer(op, rd, rs, rt, imm);
    lat = 1;
    if (keep) return;
    #1 bus.in_valid = 1'b0;
    wait_done(lat);
  endtask
  int lat;
  initial begin
    bus.in_valid = 0; bus.in_op = 0; bus.in_rd = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_imm = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_wren", bus.rf_wren, 0);
    chk("rst_ra", bus.rf_ra, 0);
    chk("rst_rb", bus.rf_rb, 0);
    chk("rst_rw", bus.rf_rw, 0);
    chk("rst_busw", bus.rf_busw, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_z", bus.flag_z, 0);
    chk("rst_c", bus.flag_c, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk) rst = 1'b1;
    issue(LI, 3, 0, 0, 16'h1234, 0, lat);
    chk("li_lat", lat, 2);
    chk("li_result", bus.result, 16'h1234);
    chk("li_z", bus.flag_z, 0);
    issue(LI, 1, 0, 0, 16'hFFFF, 0, lat);
    issue(LI, 2, 0, 0, 16'h0001, 0, lat);
    issue(ADD, 4, 1, 2, 16'h0, 0, lat);
    chk("add_lat", lat, 3);
    chk("add_result", bus.result, 16'h0000);
    chk("add_z", bus.flag_z, 1);
    chk("add_c", bus.flag_c, 1);
    issue(SUB, 5, 2, 1, 16'h0, 0, lat);
    chk("sub_result", bus.result, 16'h0002);
    chk("sub_c", bus.flag_c, 1);
    issue(SLL, 6, 2, 1, 16'h0, 0, lat);
    chk("sll_result", bus.result, 16'h8000);
    chk("sll_c", bus.flag_c, 0);
    issue(ADD, 7, 3, 2, 16'h0, 1, lat);
    issue(SRL, 8, 7, 2, 16'h0, 0, lat);
    chk("b2b_result", bus.result, 16'h091A);
    offer(AND_, 10, 3, 1, 16'h0);
    @(negedge clk);
    bus.in_op = LI; bus.in_rd = 11; bus.in_imm = 16'hBEEF;
    chk("ready_in_read", bus.in_ready, 0);
    @(negedge clk) bus.in_valid = 1'b0;
    wait_done(lat);
    chk("and_result", bus.result, 16'h1234);
    repeat (4) @(posedge clk);
    chk("no_stray_write", rf_mem[11], 16'h0);
    offer(XOR_, 3, 1, 2, 16'h0);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 chk("xor_wren_exec", bus.rf_wren, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_wren", bus.rf_wren, 0);
    chk("rst_async_done", bus.done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_result", bus.result, 0);
    chk("xor_suppressed", rf_mem[3], 16'h1234);
    for (int i = 0; i < 32; i++) chk("rf_final", rf_mem[i], m_rf[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
